// File: rtl/mat_result_writer.sv
// Result-stream sink: captures a row-major element stream into a small FIFO,
// writes each element to matrix storage, checks framing, then commits dims.
module mat_result_writer #(
    parameter int DIM_WIDTH  = 3,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DIM_WIDTH-1:0]   m_sel,
    input  logic [DIM_WIDTH-1:0]   n_sel,
    input  logic                   dst_slot,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_elem,
    input  logic                   in_row_end,
    input  logic                   in_last,
    input  logic [2*DIM_WIDTH-1:0] in_linear_idx,
    output logic                   wr_en,
    input  logic                   wr_ready,
    output logic                   wr_slot_idx,
    output logic [DIM_WIDTH-1:0]   wr_row_idx,
    output logic [DIM_WIDTH-1:0]   wr_col_idx,
    output logic [DATA_WIDTH-1:0]  wr_elem,
    output logic                   meta_wr_en,
    output logic [DIM_WIDTH-1:0]   meta_m,
    output logic [DIM_WIDTH-1:0]   meta_n
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = 2 * DIM_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_COMMIT, S_DONE, S_ERROR} state_t;

    state_t                 state_q;
    logic [DIM_WIDTH-1:0]   m_q, n_q;
    logic                   slot_q;
    logic [1:0]             err_code_q;
    logic                   ready_q, busy_q, done_q, error_q;
    logic                   meta_wr_en_q;
    logic [DIM_WIDTH-1:0]   meta_m_q, meta_n_q;
    logic [IW-1:0]          exp_idx_q;
    logic [DIM_WIDTH-1:0]   exp_col_q;
    logic                   last_seen_q;
    logic [DIM_WIDTH-1:0]   wr_row_q, wr_col_q;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;

    logic [IW-1:0]          mn_s;
    logic [IW-1:0]          last_idx_s;
    logic                   wr_en_s, pop_s, push_s, full_s;
    logic                   frame_err_s, ovf_s, push_ok_s, final_pop_s;

    assign mn_s       = {{DIM_WIDTH{1'b0}}, m_q} * {{DIM_WIDTH{1'b0}}, n_q};
    assign last_idx_s = mn_s - IW'(1);

    assign wr_en_s   = (state_q == S_RECV) && (count_q != CW'(0));
    assign pop_s     = wr_en_s && wr_ready;
    assign push_s    = (state_q == S_RECV) && in_valid;
    assign full_s    = (count_q == CW'(FIFO_DEPTH));

    // Any element after the accepted last one is a framing error too.
    assign frame_err_s = push_s && (last_seen_q
                                    || (in_linear_idx != exp_idx_q)
                                    || (in_row_end != (exp_col_q == n_q - DIM_WIDTH'(1)))
                                    || (in_last != (exp_idx_q == last_idx_s)));
    assign ovf_s       = push_s && full_s && !pop_s;
    assign push_ok_s   = push_s && !frame_err_s && !ovf_s;
    assign final_pop_s = pop_s && (wr_row_q == m_q - DIM_WIDTH'(1))
                               && (wr_col_q == n_q - DIM_WIDTH'(1));

    assign ready       = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign wr_en       = wr_en_s;
    assign wr_slot_idx = slot_q;
    assign wr_row_idx  = wr_row_q;
    assign wr_col_idx  = wr_col_q;
    assign wr_elem     = wr_en_s ? mem_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};
    assign meta_wr_en  = meta_wr_en_q;
    assign meta_m      = meta_m_q;
    assign meta_n      = meta_n_q;

    // FIFO storage; contents need no reset since wr_elem is gated by wr_en.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= in_elem;
        end
    end

    // Control FSM, stream counters, FIFO pointers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            m_q          <= '0;
            n_q          <= '0;
            slot_q       <= 1'b0;
            err_code_q   <= 2'd0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            meta_wr_en_q <= 1'b0;
            meta_m_q     <= '0;
            meta_n_q     <= '0;
            exp_idx_q    <= '0;
            exp_col_q    <= '0;
            last_seen_q  <= 1'b0;
            wr_row_q     <= '0;
            wr_col_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            meta_wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        m_q         <= m_sel;
                        n_q         <= n_sel;
                        slot_q      <= dst_slot;
                        err_code_q  <= 2'd0;
                        exp_idx_q   <= '0;
                        exp_col_q   <= '0;
                        last_seen_q <= 1'b0;
                        wr_row_q    <= '0;
                        wr_col_q    <= '0;
                        wr_ptr_q    <= '0;
                        rd_ptr_q    <= '0;
                        count_q     <= '0;
                        ready_q     <= 1'b0;
                        if ((m_sel == DIM_WIDTH'(0)) || (n_sel == DIM_WIDTH'(0))) begin
                            state_q    <= S_ERROR;
                            err_code_q <= 2'd1;
                            error_q    <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= S_RECV;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (frame_err_s || ovf_s) begin
                        state_q    <= S_ERROR;
                        err_code_q <= frame_err_s ? 2'd3 : 2'd2;
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        count_q    <= '0;
                    end else begin
                        if (push_ok_s) begin
                            wr_ptr_q  <= wr_ptr_q + AW'(1);
                            exp_idx_q <= exp_idx_q + IW'(1);
                            exp_col_q <= (exp_col_q == n_q - DIM_WIDTH'(1)) ? '0
                                                                          : exp_col_q + DIM_WIDTH'(1);
                            if (in_last) begin
                                last_seen_q <= 1'b1;
                            end
                        end
                        if (pop_s) begin
                            rd_ptr_q <= rd_ptr_q + AW'(1);
                            if (wr_col_q == n_q - DIM_WIDTH'(1)) begin
                                wr_col_q <= '0;
                                wr_row_q <= wr_row_q + DIM_WIDTH'(1);
                            end else begin
                                wr_col_q <= wr_col_q + DIM_WIDTH'(1);
                            end
                        end
                        count_q <= count_q + CW'(push_ok_s) - CW'(pop_s);
                        if (final_pop_s) begin
                            state_q      <= S_COMMIT;
                            meta_wr_en_q <= 1'b1;
                            meta_m_q     <= m_q;
                            meta_n_q     <= n_q;
                        end
                    end
                end
                S_COMMIT: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                S_ERROR: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mat_result_writer.sv
// Directed bench for mat_result_writer: stimulus pushes expected writes/events
// into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mat_result_writer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] m_sel, n_sel;
    logic       dst_slot;
    logic       ready, busy, done, error;
    logic [1:0] err_code;
    logic       in_valid;
    logic [7:0] in_elem;
    logic       in_row_end, in_last;
    logic [5:0] in_linear_idx;
    logic       wr_en, wr_ready, wr_slot_idx;
    logic [2:0] wr_row_idx, wr_col_idx;
    logic [7:0] wr_elem;
    logic       meta_wr_en;
    logic [2:0] meta_m, meta_n;

    int tests = 0;
    int fails = 0;
    int wr_en_cycles = 0;

    logic [14:0] wq[$];   // {slot, row, col, elem}
    logic [5:0]  mq[$];   // {m, n}
    logic [2:0]  eq[$];   // {is_error, err_code}

    logic        prev_stall = 1'b0;
    logic [15:0] prev_wr = '0;

    mat_result_writer #(.DIM_WIDTH(3), .DATA_WIDTH(8), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .m_sel(m_sel), .n_sel(n_sel),
        .dst_slot(dst_slot), .ready(ready), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .in_valid(in_valid), .in_elem(in_elem),
        .in_row_end(in_row_end), .in_last(in_last), .in_linear_idx(in_linear_idx),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_slot_idx(wr_slot_idx),
        .wr_row_idx(wr_row_idx), .wr_col_idx(wr_col_idx), .wr_elem(wr_elem),
        .meta_wr_en(meta_wr_en), .meta_m(meta_m), .meta_n(meta_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard writes, meta commits, completion events, stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (wr_en) wr_en_cycles++;
            if (prev_stall && wr_en)
                chk("stall_stable", {wr_en, wr_slot_idx, wr_row_idx, wr_col_idx, wr_elem}, prev_wr);
            prev_stall = wr_en && !wr_ready;
            prev_wr    = {wr_en, wr_slot_idx, wr_row_idx, wr_col_idx, wr_elem};
            if (wr_en && wr_ready) begin
                if (wq.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
                else chk("write", {wr_slot_idx, wr_row_idx, wr_col_idx, wr_elem}, wq.pop_front());
            end
            if (meta_wr_en) begin
                if (mq.size() == 0) chk("unexpected_meta", 64'd1, 64'd0);
                else chk("meta", {meta_m, meta_n}, mq.pop_front());
            end
            if (done || error) begin
                if (eq.size() == 0) chk("unexpected_event", {done, error}, 64'd0);
                else chk("event", {error, err_code}, eq.pop_front());
            end
        end
    end

    task automatic do_start(input logic [2:0] m, input logic [2:0] n, input logic s);
        m_sel = m; n_sel = n; dst_slot = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] e, input logic re, input logic last, input logic [5:0] idx);
        in_valid = 1'b1; in_elem = e; in_row_end = re; in_last = last; in_linear_idx = idx;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready && k < 100);
        chk(name, ready, 1'b1);
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {ready, busy, done, error, wr_en, meta_wr_en, err_code, wr_row_idx,
                   wr_col_idx, wr_elem, wr_slot_idx, meta_m, meta_n},
            {1'b1, 5'b0, 2'd0, 3'd0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0});
    endtask

    initial begin
        int snap;
        rst = 1'b1; start = 1'b0; m_sel = '0; n_sel = '0; dst_slot = 1'b0;
        in_valid = 1'b0; in_elem = '0; in_row_end = 1'b0; in_last = 1'b0;
        in_linear_idx = '0; wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset_state");

        // 1: 2x3 into slot 1, one element every second cycle
        @(posedge clk); #1;
        do_start(3'd2, 3'd3, 1'b1);
        chk("t1_busy", {ready, busy}, 2'b01);
        mq.push_back({3'd2, 3'd3});
        eq.push_back(3'b000);
        for (int i = 0; i < 6; i++) begin
            wq.push_back({1'b1, 3'(i / 3), 3'(i % 3), 8'(i + 1)});
            send(8'(i + 1), (i % 3) == 2, i == 5, 6'(i));
            @(negedge clk);
            chk("t1_latency", {wr_en, wr_elem}, {1'b1, 8'(i + 1)});
            @(posedge clk); #1;
        end
        wait_idle("t1_idle");
        chk("t1_drained", wq.size() + mq.size() + eq.size(), 0);

        // 2: 2x2 with wr_ready low for 10 cycles from the first push
        wr_ready = 1'b0;
        do_start(3'd2, 3'd2, 1'b0);
        mq.push_back({3'd2, 3'd2});
        eq.push_back(3'b000);
        for (int i = 0; i < 4; i++) begin
            wq.push_back({1'b0, 3'(i / 2), 3'(i % 2), 8'((i + 1) * 10)});
            send(8'((i + 1) * 10), (i % 2) == 1, i == 3, 6'(i));
        end
        repeat (6) @(posedge clk);
        #1 wr_ready = 1'b1;
        wait_idle("t2_idle");
        chk("t2_drained", wq.size() + mq.size() + eq.size(), 0);

        // 3: 3x3 with storage never ready: 9th push overflows the 8-entry FIFO
        wr_ready = 1'b0;
        do_start(3'd3, 3'd3, 1'b1);
        eq.push_back(3'b110);
        for (int i = 0; i < 9; i++)
            send(8'(i + 100), (i % 3) == 2, i == 8, 6'(i));
        @(negedge clk);
        chk("t3_wr_en_drop", {wr_en, error, err_code}, {1'b0, 1'b1, 2'd2});
        wait_idle("t3_idle");
        wr_ready = 1'b1;
        chk("t3_drained", wq.size() + mq.size() + eq.size(), 0);

        // 4: 2x2 with in_last on index 2, then a clean 1x2 run clears err_code
        do_start(3'd2, 3'd2, 1'b0);
        eq.push_back(3'b111);
        wq.push_back({1'b0, 3'd0, 3'd0, 8'h55});
        send(8'h55, 1'b0, 1'b0, 6'd0);
        @(posedge clk); #1;
        wq.push_back({1'b0, 3'd0, 3'd1, 8'h66});
        send(8'h66, 1'b1, 1'b0, 6'd1);
        @(posedge clk); #1;
        send(8'h77, 1'b0, 1'b1, 6'd2);
        wait_idle("t4_idle");
        chk("t4_err_held", err_code, 2'd3);
        chk("t4_drained", wq.size() + mq.size() + eq.size(), 0);
        do_start(3'd1, 3'd2, 1'b1);
        chk("t4_err_clear", err_code, 2'd0);
        mq.push_back({3'd1, 3'd2});
        eq.push_back(3'b000);
        wq.push_back({1'b1, 3'd0, 3'd0, 8'hA1});
        send(8'hA1, 1'b0, 1'b0, 6'd0);
        wq.push_back({1'b1, 3'd0, 3'd1, 8'hB2});
        send(8'hB2, 1'b1, 1'b1, 6'd1);
        wait_idle("t4b_idle");
        chk("t4b_drained", wq.size() + mq.size() + eq.size(), 0);

        // 5: zero row count
        snap = wr_en_cycles;
        do_start(3'd0, 3'd4, 1'b0);
        eq.push_back(3'b101);
        chk("t5_error_next", {error, err_code}, 3'b101);
        wait_idle("t5_idle");
        chk("t5_no_writes", wr_en_cycles - snap, 0);
        chk("t5_drained", eq.size(), 0);

        // 6: reset while a write is stalled, then a clean 1x1 run
        wr_ready = 1'b0;
        do_start(3'd2, 3'd2, 1'b1);
        send(8'hC3, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        chk("t6_stalled", {wr_en, wr_elem}, {1'b1, 8'hC3});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("t6_reset_vals");
        wr_ready = 1'b1;
        @(posedge clk); #1;
        do_start(3'd1, 3'd1, 1'b0);
        mq.push_back({3'd1, 3'd1});
        eq.push_back(3'b000);
        wq.push_back({1'b0, 3'd0, 3'd0, 8'h3C});
        send(8'h3C, 1'b1, 1'b1, 6'd0);
        wait_idle("t6_idle");
        chk("t6_drained", wq.size() + mq.size() + eq.size(), 0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mat_result_writer.md
Name: mat_result_writer

Overview:
Downstream sink for the matrix-operation result stream (scalar multiply and sibling ops). Captures the row-major element stream (valid/elem/row_end/last/linear_idx) into a small FIFO and writes each element back into matrix storage at a chosen destination slot using a ready/valid write handshake. Checks stream framing against the commanded m×n shape. On success it commits the result dimensions to slot metadata.

Parameters:
DIM_WIDTH, 3, row/column index width (dims 1..7)
DATA_WIDTH, 8, element width
FIFO_DEPTH, 8, capture FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin capture; honoured only when ready=1
m_sel  in  DIM_WIDTH  expected rows
n_sel  in  DIM_WIDTH  expected cols
dst_slot  in  1  destination storage slot
ready  out  1  idle, can accept start
busy  out  1  operation in progress
done  out  1  one-cycle success pulse
error  out  1  one-cycle failure pulse
err_code  out  2  0 none, 1 zero dimension, 2 FIFO overflow, 3 stream framing error; held until next accepted start
in_valid  in  1  upstream element strobe (no backpressure)
in_elem  in  DATA_WIDTH  element value
in_row_end  in  1  element is last of its row
in_last  in  1  element is last of matrix
in_linear_idx  in  2*DIM_WIDTH  upstream index; equals 0-based position of the element in the stream
wr_en  out  1  storage write request
wr_ready  in  1  storage accepts write this cycle
wr_slot_idx  out  1  = latched dst_slot
wr_row_idx  out  DIM_WIDTH  target row
wr_col_idx  out  DIM_WIDTH  target col
wr_elem  out  DATA_WIDTH  target value
meta_wr_en  out  1  one-cycle dimension commit strobe
meta_m  out  DIM_WIDTH  committed rows
meta_n  out  DIM_WIDTH  committed cols

Behaviour:
- Reset (rst=1 at edge, from any state including mid-operation): state IDLE, FIFO emptied, counters 0. Outputs: ready=1; busy, done, error, wr_en, meta_wr_en = 0; err_code, wr_row_idx, wr_col_idx, wr_elem, wr_slot_idx, meta_m, meta_n = 0. Any in-flight write is abandoned.
- States: IDLE, RECV, COMMIT, DONE, ERROR.
- IDLE: ready=1, busy=0. in_valid is ignored. On start, latch m_sel, n_sel, dst_slot, clear err_code, clear counters, set ready=0 and busy=1.
  - If m_sel==0 or n_sel==0: go to ERROR with err_code=1.
  - Otherwise go to RECV.
- RECV, push side (exp_idx counts accepted elements; exp_row/exp_col track the target position):
  - Each in_valid pushes {in_elem} into the FIFO and increments exp_idx.
  - Framing is checked on the same cycle. Error if in_linear_idx != exp_idx, or in_row_end != (exp_col==n-1), or in_last != (exp_idx==m*n-1). On error: err_code=3, go to ERROR.
  - Any in_valid after in_last has been accepted also gives err_code=3.
  - A push while the FIFO is full and no pop happens that cycle gives err_code=2, go to ERROR. A simultaneous pop frees the slot, so no overflow.
- RECV, pop side:
  - When the FIFO is non-empty, drive wr_en=1 with the head element and the write row/col counters.
  - The element transfers on wr_en && wr_ready. Then pop, advance col (wrap to 0 at n-1 and increment row).
  - While wr_en && !wr_ready, all wr_* outputs stay stable.
  - Latency: an element pushed at cycle t appears on wr_en at t+1 at the earliest.
- RECV to COMMIT: when the last element (index m*n-1) has been written.
- COMMIT: one cycle with meta_wr_en=1, meta_m=m, meta_n=n, then DONE.
- DONE: done=1 for this single cycle, busy=0. Next cycle IDLE.
- ERROR: error=1 for this single cycle, busy=0, wr_en=0, FIFO flushed. Writes already completed stand; no meta commit. Next cycle IDLE.
- Width rules:
  - Target index m*n-1 is computed at 2*DIM_WIDTH bits (max 48).
  - in_linear_idx is compared at full width.
  - No arithmetic is applied to element data; it passes through unchanged.
- start while busy is ignored.
- wr_ready while wr_en=0 is ignored.

Test Plan:
1. start m=2 n=3 slot=1; stream 1..6 every 2nd cycle with correct flags; wr_ready=1 -> writes (0,0)=1 … (1,2)=6, each 1 cycle after its push; meta_wr_en with meta_m=2, meta_n=3; one-cycle done; ready=1 after.
2. m=2 n=2, stream 10,20,30,40; wr_ready low for 10 cycles from the first push -> no loss; four writes in order with wr_* stable while stalled; done pulse.
3. m=3 n=3, wr_ready held 0, FIFO_DEPTH=8 -> 9th push hits a full FIFO -> error pulse, err_code=2, no meta_wr_en, wr_en drops.
4. m=2 n=2, in_last asserted on the element with in_linear_idx=2 -> err_code=3, no meta_wr_en; next start succeeds and err_code clears to 0.
5. start with m_sel=0 n_sel=4 -> error next cycle, err_code=1, zero wr_en cycles, ready=1 after.
6. rst asserted while wr_en=1 and stalled -> next cycle all outputs at reset values; a clean 1×1 run then completes with done.
